dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences an external inferable dual-port RAM with a registered write port and a combinational read port.
- Provides valid/ready push and pop interfaces, and owns the write and read pointers, the fill count and the full/empty flags.
- Drives the RAM write and read address ports. Read data falls through combinationally from the RAM to the pop side.
- Sits between a producer and a consumer in FPGA-targeted datapaths: CDC-free buffering and DMA staging.

Parameters:
- ADDR_WIDTH, 10, width of RAM address and pointers.
- DATA_DEPTH, 1024, number of entries. Must satisfy 2 ≤ DATA_DEPTH ≤ 2**ADDR_WIDTH. Need not be a power of 2.
- DATA_WIDTH, 32, word width.

Ports:
- Clk_CI  in  1  clock, rising edge.
- Rst_RI  in  1  reset, asynchronous, active-high.
- InValid_SI  in  1  producer has a word.
- InReady_SO  out  1  FIFO accepts a word.
- InData_DI  in  DATA_WIDTH  push data.
- OutValid_SO  out  1  FIFO has a word.
- OutReady_SI  in  1  consumer takes the word.
- OutData_DO  out  DATA_WIDTH  head-of-FIFO data.
- Count_DO  out  ADDR_WIDTH+1  current fill level.
- RamWrEn_SO  out  1  RAM write enable.
- RamWrAddr_DO  out  ADDR_WIDTH  RAM write address.
- RamWrData_DO  out  DATA_WIDTH  RAM write data.
- RamRdAddr_DO  out  ADDR_WIDTH  RAM read address.
- RamRdData_DI  in  DATA_WIDTH  RAM read data (combinational from RamRdAddr_DO).

Behaviour:
- Clocking and reset:
  - One clock domain, Clk_CI. Rst_RI is asynchronous and active-high.
  - All state clears immediately on assertion: WrPtr=0, RdPtr=0, Count=0.
- Output values during and after reset:
  - OutValid_SO=0, InReady_SO=1, Count_DO=0, RamWrEn_SO=0.
  - RamWrAddr_DO=0, RamRdAddr_DO=0.
- Handshake definitions:
  - push = InValid_SI & InReady_SO.
  - pop = OutValid_SO & OutReady_SI.
  - InReady_SO = (Count != DATA_DEPTH).
  - OutValid_SO = (Count != 0).
  - InReady_SO does not depend on OutReady_SI: no push while full, even if a pop occurs in the same cycle.
  - OutValid_SO does not depend on InValid_SI: no fall-through while empty.
- RAM port drive (all combinational):
  - RamWrEn_SO = push.
  - RamWrAddr_DO = WrPtr.
  - RamWrData_DO = InData_DI.
  - RamRdAddr_DO = RdPtr.
  - OutData_DO = RamRdData_DI.
  - OutData_DO is undefined when OutValid_SO=0.
- Pointer update:
  - On push, WrPtr advances: WrPtr = (WrPtr == DATA_DEPTH-1) ? 0 : WrPtr+1.
  - On pop, RdPtr advances with the same wrap rule.
  - Wrap occurs at DATA_DEPTH-1, not at 2**ADDR_WIDTH-1.
- Count update:
  - push only: +1. pop only: -1. Both or neither: unchanged.
  - Count never exceeds DATA_DEPTH and never underflows, guaranteed by the gating above.
- Latency:
  - A word pushed at edge N is visible on OutData_DO with OutValid_SO=1 after edge N (one cycle) when the FIFO was empty.
  - Pop takes effect at the edge; the next word is visible in the following cycle with zero bubble.
- Simultaneous push and pop with 0 < Count < DATA_DEPTH: both proceed, Count is held, and both pointers advance.
- Reset mid-operation: contents are discarded logically (RAM data is not cleared) and the FIFO reads empty.
- Inputs are sampled only on the rising edge. InData_DI must be stable while InValid_SI=1 and InReady_SO=1.
- Simulation-only checks, between pragma translate_off/on:
  - Assert on push while InReady_SO=0 with InValid_SI held and InData_DI changed. This is a warning only.
  - Assert on DATA_DEPTH > 2**ADDR_WIDTH. This is an error.

Optional Feature:
- Macro: DPRAM_FIFO_FLUSH_EN.
- When defined:
  - Adds input port Flush_SI (1 bit, in, synchronous).
  - When Flush_SI=1 at an edge, WrPtr=0, RdPtr=0 and Count=0, with priority over any simultaneous push or pop.
  - A push in the flush cycle is dropped; RamWrEn_SO is forced to 0 that cycle.
  - InReady_SO and OutValid_SO are not gated by Flush_SI in that cycle.
- When undefined: no Flush_SI port, and the logic is absent.

Test Plan:
- Reset then idle, DATA_DEPTH=5, ADDR_WIDTH=3 -> OutValid_SO=0, InReady_SO=1, Count_DO=0, RamWrEn_SO=0.
- Push 0xA1 with OutReady_SI=0 -> next cycle OutValid_SO=1, OutData_DO=0xA1, Count_DO=1. Pop -> Count_DO=0, OutValid_SO=0.
- Push 5 words 0x10..0x14 -> InReady_SO=0, Count_DO=5. Assert InValid_SI with 0x15 -> no RamWrEn_SO, Count_DO stays 5. Pop all -> order 0x10..0x14.
- Wrap test, DATA_DEPTH=5:
  - Stimulus: 12 push/pop pairs at Count=2, driven every cycle.
  - Required: RamWrAddr_DO sequence 2,3,4,0,1,2...; data order preserved; Count_DO constant at 2.
- Full with OutReady_SI=1 and InValid_SI=1 -> pop only; Count_DO 5→4; next cycle push accepted, Count_DO=5.
- Rst_RI pulse between edges at Count=3 -> immediately OutValid_SO=0 and Count_DO=0. With DPRAM_FIFO_FLUSH_EN: Flush_SI with push at Count=3 -> Count_DO=0, RamWrEn_SO=0.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl
// Synchronous FIFO controller for an external dual-port RAM that has a
// registered write port and a combinational read port. The controller owns
// the write/read pointers, the fill count and the full/empty handshakes, and
// drives the RAM address ports. Head-of-FIFO data falls through from the RAM
// read port to OutData_DO with no extra register.
//
// Ports:
//   Clk_CI        clock, rising edge
//   Rst_RI        asynchronous active-high reset
//   InValid_SI    producer has a word
//   InReady_SO    FIFO can accept a word (not full)
//   InData_DI     push data
//   OutValid_SO   FIFO holds a word (not empty)
//   OutReady_SI   consumer takes the head word
//   OutData_DO    head word (undefined while OutValid_SO=0)
//   Count_DO      current fill level
//   RamWrEn_SO    RAM write enable
//   RamWrAddr_DO  RAM write address
//   RamWrData_DO  RAM write data
//   RamRdAddr_DO  RAM read address
//   RamRdData_DI  RAM read data, combinational from RamRdAddr_DO
//   Flush_SI      synchronous flush, present only with DPRAM_FIFO_FLUSH_EN
//
// Optional feature macro: DPRAM_FIFO_FLUSH_EN
// -----------------------------------------------------------------------------
module dpram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_DEPTH = 1024,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RI,
`ifdef DPRAM_FIFO_FLUSH_EN
   input  logic                  Flush_SI,
`endif
   input  logic                  InValid_SI,
   output logic                  InReady_SO,
   input  logic [DATA_WIDTH-1:0] InData_DI,
   output logic                  OutValid_SO,
   input  logic                  OutReady_SI,
   output logic [DATA_WIDTH-1:0] OutData_DO,
   output logic [ADDR_WIDTH:0]   Count_DO,
   output logic                  RamWrEn_SO,
   output logic [ADDR_WIDTH-1:0] RamWrAddr_DO,
   output logic [DATA_WIDTH-1:0] RamWrData_DO,
   output logic [ADDR_WIDTH-1:0] RamRdAddr_DO,
   input  logic [DATA_WIDTH-1:0] RamRdData_DI
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DATA_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DATA_DEPTH - 1);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  push;
   logic                  pop;
   logic                  flush;

   // Pointers wrap at the last used entry so non-power-of-2 depths work.
   function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

`ifdef DPRAM_FIFO_FLUSH_EN
   assign flush = Flush_SI;
`else
   assign flush = 1'b0;
`endif

   // Ready/valid come from the count alone: no pass-through while full and
   // no fall-through while empty.
   assign InReady_SO  = (count != DEPTH_CNT);
   assign OutValid_SO = (count != '0);
   assign push        = InValid_SI & InReady_SO;
   assign pop         = OutValid_SO & OutReady_SI;

   assign RamWrEn_SO   = push & ~flush;
   assign RamWrAddr_DO = wr_ptr;
   assign RamWrData_DO = InData_DI;
   assign RamRdAddr_DO = rd_ptr;
   assign OutData_DO   = RamRdData_DI;
   assign Count_DO     = count;

   // Pointer and count state; flush wins over any push or pop in its cycle.
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   // A stalled producer must hold its word until it is accepted.
   assert property (@(posedge Clk_CI) disable iff (Rst_RI)
      (InValid_SI && !InReady_SO) |=> (!InValid_SI || $stable(InData_DI)))
      else $warning("dpram_fifo_ctrl: InData_DI changed while stalled");

   assert property (@(posedge Clk_CI) DATA_DEPTH <= (2 ** ADDR_WIDTH))
      else $error("dpram_fifo_ctrl: DATA_DEPTH exceeds 2**ADDR_WIDTH");
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

   localparam int AW = 3;
   localparam int DD = 5;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW:0]   count;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata;
`ifdef DPRAM_FIFO_FLUSH_EN
   logic          flush;
`endif

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_q[$];
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW)) dut (
      .Clk_CI       (clk),
      .Rst_RI       (rst),
`ifdef DPRAM_FIFO_FLUSH_EN
      .Flush_SI     (flush),
`endif
      .InValid_SI   (in_valid),
      .InReady_SO   (in_ready),
      .InData_DI    (in_data),
      .OutValid_SO  (out_valid),
      .OutReady_SI  (out_ready),
      .OutData_DO   (out_data),
      .Count_DO     (count),
      .RamWrEn_SO   (ram_we),
      .RamWrAddr_DO (ram_waddr),
      .RamWrData_DO (ram_wdata),
      .RamRdAddr_DO (ram_raddr),
      .RamRdData_DI (ram_rdata)
   );

   // Behavioural RAM: registered write, combinational read.
   always_ff @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
   assign ram_rdata = mem[ram_raddr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected: got 0x%0h expected none at %0t", out_data, $time);
         end else begin
            chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef DPRAM_FIFO_FLUSH_EN
      flush = 1'b0;
`endif
      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready",  32'(in_ready),  1);
      chk("rst_count",     32'(count),     0);
      chk("rst_wr_en",     32'(ram_we),    0);
      chk("rst_wr_addr",   32'(ram_waddr), 0);
      chk("rst_rd_addr",   32'(ram_raddr), 0);
      step();
      rst = 1'b0;
      step();

      // Single word push then pop
      in_valid = 1'b1; in_data = 8'hA1; exp_q.push_back(8'hA1);
      @(negedge clk);
      chk("a1_wr_en",   32'(ram_we),    1);
      chk("a1_wr_addr", 32'(ram_waddr), 0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("a1_out_valid", 32'(out_valid), 1);
      chk("a1_count",     32'(count),     1);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("a1_count_after_pop", 32'(count),     0);
      chk("a1_valid_after_pop", 32'(out_valid), 0);
      step();

      // Fill to full, attempt overflow, drain
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
         step();
      end
      in_data = 8'h15;
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_count",    32'(count),    5);
      chk("full_wr_en",    32'(ram_we),   0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("full_count_hold", 32'(count), 5);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("drain_count", 32'(count), 0);
      step();

      // Asynchronous reset pulse between edges at Count=3
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h50 + i); exp_q.push_back(8'(8'h50 + i));
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_count", 32'(count), 3);
      step();
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_count",     32'(count),     0);
      chk("arst_in_ready",  32'(in_ready),  1);
      rst = 1'b0;
      exp_q.delete();
      step();

      // Wrap: two words preloaded, then 12 simultaneous push/pop cycles
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h30 + i); exp_q.push_back(8'(8'h30 + i));
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h40 + i); exp_q.push_back(8'(8'h40 + i));
         @(negedge clk);
         chk("wrap_wr_addr", 32'(ram_waddr), 32'((2 + i) % 5));
         chk("wrap_rd_addr", 32'(ram_raddr), 32'(i % 5));
         chk("wrap_count",   32'(count),     2);
         step();
      end
      in_valid = 1'b0;
      step(); step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("wrap_end_count", 32'(count), 0);
      step();

      // Full with both handshakes: pop only, then push accepted
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h60 + i); exp_q.push_back(8'(8'h60 + i));
         step();
      end
      in_data = 8'h65; out_ready = 1'b1;
      @(negedge clk);
      chk("fb_wr_en", 32'(ram_we), 0);
      step();
      out_ready = 1'b0; exp_q.push_back(8'h65);
      @(negedge clk);
      chk("fb_count_4", 32'(count),  4);
      chk("fb_wr_en2",  32'(ram_we), 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("fb_count_5", 32'(count), 5);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("fb_drain_count", 32'(count), 0);
      step();

`ifdef DPRAM_FIFO_FLUSH_EN
      // Flush with a simultaneous push at Count=3
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h70 + i); exp_q.push_back(8'(8'h70 + i));
         step();
      end
      in_data = 8'h73; flush = 1'b1;
      @(negedge clk);
      chk("flush_wr_en",     32'(ram_we),    0);
      chk("flush_in_ready",  32'(in_ready),  1);
      chk("flush_out_valid", 32'(out_valid), 1);
      step();
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("flush_count",     32'(count),     0);
      chk("flush_valid_end", 32'(out_valid), 0);
      step();
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
